// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing for the PWM button front-end.
// Defaults assume a 50 MHz clk: 1 ms debounce, 0.5 s start, 0.1 s rate.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_START    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;
    localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/pwm_button_ctrl_if.sv
// Button inputs, consume tick and request/level outputs of the front-end.
// master drives buttons and tick; slave is the controller.
interface pwm_button_ctrl_if;

    logic btn_up_raw;
    logic btn_dn_raw;
    logic consume_tick;
    logic duty_inc;
    logic duty_dec;
    logic btn_up_level;
    logic btn_dn_level;

    modport master (
        output btn_up_raw,
        output btn_dn_raw,
        output consume_tick,
        input  duty_inc,
        input  duty_dec,
        input  btn_up_level,
        input  btn_dn_level
    );

    modport slave (
        input  btn_up_raw,
        input  btn_dn_raw,
        input  consume_tick,
        output duty_inc,
        output duty_dec,
        output btn_up_level,
        output btn_dn_level
    );

endinterface

// File: rtl/pwm_button_ctrl_debounce.sv
// Synchroniser chain plus debounce counter for one raw push-button.
// level follows synced only after DEBOUNCE_CYCLES unbroken cycles of difference.
module btn_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_button_ctrl.sv
// Debounced up/down buttons -> auto-repeating duty requests held until
// the PWM stage consumes them on consume_tick.
module pwm_button_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_START    = DEF_REPEAT_START,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    pwm_button_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(REPEAT_START - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam bit               RPT_EN     = (REPEAT_RATE != 0);

    // index 0 = up, 1 = down
    logic [1:0]       level;
    logic [1:0]       ev;
    logic             both;
    rpt_state_t       state [2];
    logic [CNT_W-1:0] rcnt  [2];
    logic             inc;
    logic             dec;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_up (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn_up_raw),
        .level(level[0])
    );

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_dn (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn_dn_raw),
        .level(level[1])
    );

    assign both = &level;

    always_comb begin
        ev = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (level[b] && !both) begin
                unique case (state[b])
                    IDLE:    ev[b] = 1'b1;
                    DELAY:   ev[b] = RPT_EN && (rcnt[b] == START_LAST);
                    REPEAT:  ev[b] = (rcnt[b] == RATE_LAST);
                    default: ev[b] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= IDLE;
                rcnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!level[b] || both) begin
                    state[b] <= IDLE;
                    rcnt[b]  <= '0;
                end else begin
                    unique case (state[b])
                        IDLE: begin
                            state[b] <= DELAY;
                            rcnt[b]  <= '0;
                        end
                        DELAY: begin
                            // with repeat disabled rcnt parks at START_LAST
                            if (rcnt[b] != START_LAST) begin
                                rcnt[b] <= rcnt[b] + CNT_W'(1);
                            end else if (RPT_EN) begin
                                state[b] <= REPEAT;
                                rcnt[b]  <= '0;
                            end
                        end
                        REPEAT: begin
                            if (rcnt[b] == RATE_LAST) rcnt[b] <= '0;
                            else rcnt[b] <= rcnt[b] + CNT_W'(1);
                        end
                        default: begin
                            state[b] <= IDLE;
                            rcnt[b]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // a new event beats a same-cycle consume, and flips direction outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc <= 1'b0;
            dec <= 1'b0;
        end else begin
            priority case (1'b1)
                ev[0]: begin
                    inc <= 1'b1;
                    dec <= 1'b0;
                end
                ev[1]: begin
                    inc <= 1'b0;
                    dec <= 1'b1;
                end
                bus.consume_tick: begin
                    inc <= 1'b0;
                    dec <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.duty_inc     = inc;
    assign bus.duty_dec     = dec;
    assign bus.btn_up_level = level[0];
    assign bus.btn_dn_level = level[1];

endmodule

// File: tb/tb_pwm_button_ctrl.sv
// Bench for pwm_button_ctrl: two instances (repeat rate 5 and 0) on shared
// stimulus, checked per cycle against a hold-time model plus directed cases.
module tb_pwm_button_ctrl;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int START = 10;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic up_raw = 1'b0;
    logic dn_raw = 1'b0;
    logic cons   = 1'b0;

    always #5 clk = ~clk;

    pwm_button_ctrl_if bus_a ();
    pwm_button_ctrl_if bus_b ();

    assign bus_a.btn_up_raw   = up_raw;
    assign bus_a.btn_dn_raw   = dn_raw;
    assign bus_a.consume_tick = cons;
    assign bus_b.btn_up_raw   = up_raw;
    assign bus_b.btn_dn_raw   = dn_raw;
    assign bus_b.consume_tick = cons;

    pwm_button_ctrl #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_START(START), .REPEAT_RATE(5), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    pwm_button_ctrl #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_START(START), .REPEAT_RATE(0), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int duty_obs = 0;

    // reference model: levels from a raw-sample window, events from hold time
    bit m_lvl [2];
    bit rawq  [2][$];
    bit hist  [2][$];
    int hold  [2][2];
    int pend  [2];

    function automatic int rate_of(int d);
        return (d == 0) ? 5 : 0;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 1'b0;
            rawq[b]  = {};
            hist[b]  = {};
            for (int i = 0; i < SYNC; i++) rawq[b].push_back(1'b0);
            for (int i = 0; i < DEB; i++) hist[b].push_back(1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            hold[d][0] = 0;
            hold[d][1] = 0;
            pend[d]    = 0;
        end
    endtask

    task automatic model_step(input bit u, input bit dn, input bit c);
        bit raw [2];
        bit ev  [2];
        bit act;
        bit s;
        bit flip;
        int h;
        raw[0] = u;
        raw[1] = dn;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                act = m_lvl[b] && !m_lvl[1-b];
                h = hold[d][b];
                ev[b] = act && (h == 0 || (rate_of(d) != 0 && h >= START
                        && (h - START) % rate_of(d) == 0));
                hold[d][b] = act ? h + 1 : 0;
            end
            if (ev[0]) pend[d] = 1;
            else if (ev[1]) pend[d] = -1;
            else if (c) pend[d] = 0;
        end
        for (int b = 0; b < 2; b++) begin
            s = rawq[b].pop_front();
            rawq[b].push_back(raw[b]);
            void'(hist[b].pop_front());
            hist[b].push_back(s);
            flip = 1'b1;
            foreach (hist[b][i]) if (hist[b][i] == m_lvl[b]) flip = 1'b0;
            if (flip) m_lvl[b] = !m_lvl[b];
        end
    endtask

    function automatic logic [3:0] model_out(int d);
        return {m_lvl[0], m_lvl[1], pend[d] == 1, pend[d] == -1};
    endfunction

    function automatic logic [3:0] dut_out(int d);
        if (d == 0)
            return {bus_a.btn_up_level, bus_a.btn_dn_level,
                    bus_a.duty_inc, bus_a.duty_dec};
        return {bus_b.btn_up_level, bus_b.btn_dn_level,
                bus_b.duty_inc, bus_b.duty_dec};
    endfunction

    task automatic check(input string name,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, got, exp);
        end
    endtask

    // one clock: drive, model the edge, compare both instances
    task automatic cyc(input bit u, input bit dn, input bit c);
        logic pi;
        logic pd;
        up_raw = u;
        dn_raw = dn;
        cons   = c;
        pi = bus_a.duty_inc;
        pd = bus_a.duty_dec;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(u, dn, c);
        if (!rst && c) duty_obs += int'(pi) - int'(pd);
        #1;
        check("cycle_a", dut_out(0), model_out(0));
        check("cycle_b", dut_out(1), model_out(1));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit up;
        bit dn;
        bit c;
        int n;
        bit e_lvl;
        bit e_inc;
        bit e_dec;
    } vec_t;

    vec_t tbl [8];
    int   exp_rpt [7];

    initial begin
        int k;
        int kf;
        int ki;
        int nb;
        int d0;
        int inc_hi;
        bit held;
        bit none;
        bit pa;
        bit pb;
        bit prev_dec;
        bit ru;
        bit rd;
        bit rc;
        int ka [$];

        tbl[0] = '{0, 0, 0, 3,  0, 0, 0};
        tbl[1] = '{1, 0, 0, 5,  0, 0, 0};
        tbl[2] = '{1, 0, 0, 2,  1, 1, 0};
        tbl[3] = '{1, 0, 0, 5,  1, 1, 0};
        tbl[4] = '{0, 0, 1, 1,  1, 0, 0};
        tbl[5] = '{0, 1, 0, 8,  0, 0, 1};
        tbl[6] = '{0, 0, 1, 1,  0, 0, 0};
        tbl[7] = '{0, 0, 0, 10, 0, 0, 0};
        exp_rpt = '{7, 17, 22, 27, 32, 37, 42};

        model_reset();
        @(negedge clk);
        cyc(0, 0, 0);
        check("reset_state", dut_out(0), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].n) cyc(tbl[i].up, tbl[i].dn, tbl[i].c);
            check($sformatf("table_row%0d", i),
                  {bus_a.btn_up_level, bus_a.duty_inc, bus_a.duty_dec},
                  {tbl[i].e_lvl, tbl[i].e_inc, tbl[i].e_dec});
        end

        // bounce then steady press
        do_reset();
        for (int i = 0; i < 6; i++) cyc(i % 2 == 0, 0, 1);
        kf = -1;
        ki = -1;
        inc_hi = 0;
        for (int j = 1; j <= 30; j++) begin
            cyc(1, 0, 1);
            if (kf < 0 && bus_a.btn_up_level) kf = j;
            if (ki < 0 && bus_a.duty_inc) ki = j;
            if (j < 17 && bus_a.duty_inc) inc_hi++;
        end
        check("bounce_level_edge", kf, 6);
        check("bounce_inc_edge", ki, 7);
        check("bounce_inc_cycles", inc_hi, 1);

        // request held until consumed
        do_reset();
        d0 = duty_obs;
        k = 0;
        while (!bus_a.duty_inc && k < 20) begin
            cyc(1, 0, 0);
            k++;
        end
        check("hs_press_edges", k, 7);
        held = 1'b1;
        repeat (20) begin
            cyc(1, 0, 0);
            if (!bus_a.duty_inc) held = 1'b0;
        end
        check("hs_held", held, 1);
        cyc(1, 0, 1);
        check("hs_cleared", bus_a.duty_inc, 0);
        check("hs_duty_step", duty_obs - d0, 1);
        repeat (8) cyc(0, 0, 0);

        // auto-repeat, and the rate-0 instance alongside
        do_reset();
        nb = 0;
        pa = 1'b0;
        pb = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            cyc(j <= 40, 0, 1);
            if (bus_a.duty_inc && !pa) ka.push_back(j);
            if (bus_b.duty_inc && !pb) nb++;
            pa = bus_a.duty_inc;
            pb = bus_b.duty_inc;
        end
        check("rpt_events", ka.size(), 7);
        check("rpt_events_rate0", nb, 1);
        for (int i = 0; i < 7; i++)
            check($sformatf("rpt_edge%0d", i),
                  (i < ka.size()) ? ka[i] : -1, exp_rpt[i]);

        // both buttons held
        do_reset();
        none = 1'b1;
        repeat (50) begin
            cyc(1, 1, 0);
            if (bus_a.duty_inc || bus_a.duty_dec) none = 1'b0;
        end
        check("both_quiet", none, 1);
        check("both_levels",
              {bus_a.btn_up_level, bus_a.btn_dn_level}, 3);
        kf = -1;
        ki = -1;
        for (int j = 1; j <= 20; j++) begin
            cyc(1, 0, 0);
            if (kf < 0 && !bus_a.btn_dn_level) kf = j;
            if (ki < 0 && bus_a.duty_inc) ki = j;
        end
        check("both_release_dn_edge", kf, 6);
        check("both_release_inc_edge", ki, 7);
        repeat (8) cyc(0, 0, 0);

        // direction swap and set-beats-consume
        do_reset();
        k = 0;
        while (!bus_a.duty_dec && k < 20) begin
            cyc(0, 1, 0);
            k++;
        end
        repeat (8) cyc(0, 0, 0);
        check("swap_dec_pending", bus_a.duty_dec, 1);
        prev_dec = 1'b0;
        k = 0;
        while (!bus_a.duty_inc && k < 20) begin
            prev_dec = bus_a.duty_dec;
            cyc(1, 0, 0);
            k++;
        end
        check("swap_one_edge",
              {prev_dec, bus_a.duty_dec, bus_a.duty_inc}, 5);
        repeat (9) cyc(1, 0, 0);
        cyc(1, 0, 1);
        check("collide_set_wins", bus_a.duty_inc, 1);
        cyc(1, 0, 1);
        check("collide_then_clear", bus_a.duty_inc, 0);
        repeat (8) cyc(0, 0, 0);

        // asynchronous reset mid-repeat
        do_reset();
        k = 0;
        while (!bus_a.duty_inc && k < 20) begin
            cyc(1, 0, 0);
            k++;
        end
        repeat (15) cyc(1, 0, 0);
        check("pre_rst_inc", bus_a.duty_inc, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_a", dut_out(0), 0);
        check("rst_async_b", dut_out(1), 0);
        model_reset();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        rst = 1'b0;
        k = 0;
        while (!bus_a.duty_inc && k < 20) begin
            cyc(1, 0, 0);
            k++;
        end
        check("rst_repress_edges", k, 7);

        // randomized runs against the model
        do_reset();
        ru = 1'b0;
        rd = 1'b0;
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 9) == 0) ru = !ru;
            if ($urandom_range(0, 11) == 0) rd = !rd;
            rc = ($urandom_range(0, 3) == 0);
            cyc(ru, rd, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_button_ctrl.md
Name: pwm_button_ctrl

Overview:
Front-end for the PWM block's duty_inc/duty_dec controls.
- Synchronises and debounces two raw push-buttons (up/down).
- Turns presses into duty-change requests, with auto-repeat while a button is held.
- Holds each request until the PWM stage consumes it. The PWM only samples duty_inc/duty_dec on en && enable_tick, so a single-clk pulse would be lost.

Parameters:
SYNC_STAGES, 2, synchroniser flops per button input (min 2)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles of a changed level before the debounced level follows (min 1)
REPEAT_START, 25000000, clk cycles from debounced press to first auto-repeat event
REPEAT_RATE, 5000000, clk cycles between subsequent auto-repeat events; 0 disables auto-repeat
CNT_W, 26, width of debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_START, REPEAT_RATE)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
btn_up_raw  in  1  raw up button, asynchronous, active-high
btn_dn_raw  in  1  raw down button, asynchronous, active-high
consume_tick  in  1  high in cycles where the PWM samples its controls (wired to en && enable_tick)
duty_inc  out  1  pending increment request, to PWM duty_inc
duty_dec  out  1  pending decrement request, to PWM duty_dec
btn_up_level  out  1  debounced up level
btn_dn_level  out  1  debounced down level

Behaviour:
Reset:
- All flops clear: synchronisers, counters, debounced levels, pending bits, FSMs to IDLE.
- All outputs 0 immediately on rst assertion, including mid-operation.

Synchroniser:
- SYNC_STAGES flop chain per button; the last stage is "synced".

Debounce (per button):
- synced != level: counter increments each cycle.
- On the cycle the counter equals DEBOUNCE_CYCLES-1: level <= synced and counter clears.
- synced == level: counter clears. Any bounce restarts the count.
- Latency from a clean raw edge to a level change: SYNC_STAGES + DEBOUNCE_CYCLES clk edges.

Repeat FSM (per button): states IDLE, DELAY, REPEAT; repeat counter rcnt.
- IDLE: level rises -> emit event, rcnt=0, go DELAY.
- DELAY: rcnt increments. rcnt==REPEAT_START-1 -> emit event, rcnt=0, go REPEAT (REPEAT_RATE=0: stay DELAY, rcnt saturates, no event).
- REPEAT: rcnt increments. rcnt==REPEAT_RATE-1 -> emit event, rcnt=0.
- Any state: level low -> IDLE, rcnt=0.
- Both levels high: both FSMs forced to IDLE and no events generated; already-pending requests are kept. After one button is released, the other button, if still held, generates a fresh press event on the next cycle.
- A button high at reset release starts with level=0, so it yields a normal press after debounce.

Request hold:
- An event sets the pending bit on the next edge; duty_inc/duty_dec are the pending bits, registered.
- Pending clears on the edge where consume_tick=1 and the bit is set.
- Same-cycle event and consume: set wins (bit stays 1).
- Event while the same direction is pending: dropped (no queueing).
- Up event while dec pending: duty_dec clears and duty_inc sets on the same edge; symmetric for a down event.
- duty_inc and duty_dec are never both 1.

Decomposition:
- Package pwm_ctrl_pkg: FSM state encodings (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2) and the default timing constants.
- One sub-module, btn_debounce (synchroniser + debounce counter, output level), instantiated twice.
- Repeat FSMs and request logic stay in the top module.

Test Plan:
Params for all: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_START=10, REPEAT_RATE=5.
- Bounce: btn_up_raw toggles every cycle for 6 cycles, then steady 1 for 30 cycles, consume_tick=1 -> btn_up_level rises 6 edges after settling; duty_inc high exactly 1 cycle, 7 edges after settling; no later event before cycle 17.
- Handshake: single up press, consume_tick=0 for 20 cycles then 1 for one cycle -> duty_inc held 1 throughout, falls on the edge after the tick; PWM model duty_cycle increments by exactly 1.
- Auto-repeat: hold up 40 cycles after debounce, consume_tick=1 -> events at press cycle P, P+10, P+15, P+20, P+25, P+30, P+35 (7 total); release -> no further events; REPEAT_RATE=0 rerun -> 1 event only.
- Both held: up and dn raw high together for 50 cycles -> duty_inc=duty_dec=0 throughout; release dn -> one duty_inc event on the next cycle.
- Swap/collision: dn pending with consume_tick=0, then up press -> on one edge duty_dec 1->0 and duty_inc 0->1; event coinciding with consume_tick on a pending inc -> duty_inc stays 1.
- Reset mid-hold: assert rst while duty_inc=1 and FSM in REPEAT -> all outputs 0 asynchronously; release with btn still high -> new press event after 7 edges.
